// File: rtl/score_tracker_bcd.sv
// Pong score tracker: detects paddle hits/misses, keeps BCD hit/miss scores with a miss-limit
// game-over, and stretches a retriggerable sound pulse. Scores/events lag detection by one cycle.
module score_tracker_bcd #(
  parameter int DIGITS       = 2,
  parameter int PADDLE_HALF  = 56,
  parameter int HIT_Y        = 448,
  parameter int MISS_Y       = 463,
  parameter int MAX_MISSES   = 5,
  parameter int SOUND_CYCLES = 2500000
) (
  input  logic                clk,
  input  logic                Locked,
  input  logic                reset_score,
  input  logic [9:0]          BallCentreX,
  input  logic [9:0]          BallCentreY,
  input  logic [9:0]          PaddleCentreX,
  output logic                PaddleHit,
  output logic                HitEvent,
  output logic                MissEvent,
  output logic [4*DIGITS-1:0] HitScore,
  output logic [4*DIGITS-1:0] MissScore,
  output logic                GameOver,
  output logic                TrigSound,
  output logic                SoundSel
);

  localparam int          SW      = $clog2(SOUND_CYCLES + 1);
  localparam logic [10:0] HALF    = 11'(PADDLE_HALF);
  localparam logic [10:0] HIT_YL  = 11'(HIT_Y);
  localparam logic [10:0] MISS_YL = 11'(MISS_Y);
  localparam logic [6:0]  MAX_L   = 7'(MAX_MISSES);
  localparam bit          OVER_EN = (MAX_MISSES != 0);

  typedef enum logic [1:0] {IDLE, HIT, MISS, OVER} state_t;

  state_t        state, state_nxt;
  logic [10:0]   bx, by, px, lo, hi;
  logic          paddle_miss, count_hit, count_miss;
  logic [6:0]    miss_cnt;
  logic [SW-1:0] snd_cnt;

  function automatic logic [4*DIGITS-1:0] bcd_inc(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    logic                carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (carry) begin
        if (v[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
        end else begin
          r[4*d +: 4] = v[4*d +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Widen to 11 bits so hi never wraps and lo can be clamped at zero.
  assign bx = {1'b0, BallCentreX};
  assign by = {1'b0, BallCentreY};
  assign px = {1'b0, PaddleCentreX};
  assign lo = (px >= HALF) ? (px - HALF) : 11'd0;
  assign hi = px + HALF;

  assign PaddleHit   = (bx >= lo) && (bx <= hi) && (by >= HIT_YL);
  assign paddle_miss = (by >= MISS_YL) && !PaddleHit;

  always_comb begin
    state_nxt  = state;
    count_hit  = 1'b0;
    count_miss = 1'b0;
    if (reset_score) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (PaddleHit) begin
            state_nxt = HIT;
            count_hit = 1'b1;
          end else if (paddle_miss) begin
            state_nxt  = MISS;
            count_miss = 1'b1;
          end
        end
        HIT: begin
          if (!PaddleHit) state_nxt = IDLE;
        end
        MISS: begin
          if (!paddle_miss) state_nxt = (OVER_EN && miss_cnt >= MAX_L) ? OVER : IDLE;
        end
        OVER:    state_nxt = OVER;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!Locked) begin
      state     <= IDLE;
      HitScore  <= '0;
      MissScore <= '0;
      miss_cnt  <= '0;
      HitEvent  <= 1'b0;
      MissEvent <= 1'b0;
      snd_cnt   <= '0;
      SoundSel  <= 1'b0;
    end else begin
      state     <= state_nxt;
      HitEvent  <= count_hit;
      MissEvent <= count_miss;
      if (reset_score) begin
        HitScore  <= '0;
        MissScore <= '0;
        miss_cnt  <= '0;
      end else begin
        if (count_hit) HitScore <= bcd_inc(HitScore);
        if (count_miss) begin
          MissScore <= bcd_inc(MissScore);
          if (miss_cnt != 7'd127) miss_cnt <= miss_cnt + 7'd1;
        end
      end
      // Sound counter only follows events; score clears leave it running.
      if (HitEvent || MissEvent) begin
        snd_cnt  <= SW'(SOUND_CYCLES);
        SoundSel <= MissEvent;
      end else if (snd_cnt != '0) begin
        snd_cnt <= snd_cnt - SW'(1);
      end
    end
  end

  assign GameOver  = (state == OVER);
  assign TrigSound = (snd_cnt != '0);

endmodule

// File: tb/tb_score_tracker_bcd.sv
// Scoreboard bench for score_tracker_bcd: directed test-plan sequences then randomized play,
// checked against an integer-arithmetic game model.
module tb_score_tracker_bcd;
  localparam int PH = 56, HY = 448, MY = 463, MAXM = 3, SND = 4;

  logic       clk = 1'b0;
  logic       Locked, reset_score;
  logic [9:0] bx, by, px;
  logic       PaddleHit, HitEvent, MissEvent, GameOver, TrigSound, SoundSel;
  logic [7:0] HitScore, MissScore;

  always #5 clk = ~clk;

  score_tracker_bcd #(
    .DIGITS(2), .PADDLE_HALF(PH), .HIT_Y(HY), .MISS_Y(MY),
    .MAX_MISSES(MAXM), .SOUND_CYCLES(SND)
  ) dut (
    .clk(clk), .Locked(Locked), .reset_score(reset_score),
    .BallCentreX(bx), .BallCentreY(by), .PaddleCentreX(px),
    .PaddleHit(PaddleHit), .HitEvent(HitEvent), .MissEvent(MissEvent),
    .HitScore(HitScore), .MissScore(MissScore), .GameOver(GameOver),
    .TrigSound(TrigSound), .SoundSel(SoundSel)
  );

  typedef struct packed {
    logic       miss;
    logic [7:0] hs;
    logic [7:0] ms;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  int m_hits = 0, m_misses = 0, m_mcount = 0, m_snd = 0;
  bit m_sel = 0, m_over = 0, m_hold_hit = 0, m_hold_miss = 0;
  bit m_hit_ev = 0, m_miss_ev = 0, armed = 0;

  function automatic bit in_win(int x, int y, int p);
    int lo;
    lo = p - PH;
    if (lo < 0) lo = 0;
    return (x >= lo) && (x <= p + PH) && (y >= HY);
  endfunction

  function automatic logic [7:0] bcd(int n);
    return 8'((n / 10) * 16 + (n % 10));
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: game rules applied at each clock edge to the inputs then present.
  always @(posedge clk) begin : model
    int x, y, p;
    bit wh, wm, nh, nm;
    x  = int'(bx);
    y  = int'(by);
    p  = int'(px);
    wh = in_win(x, y, p);
    wm = (y >= MY) && !wh;
    nh = 0;
    nm = 0;
    if (!Locked) begin
      m_hits = 0; m_misses = 0; m_mcount = 0; m_snd = 0; m_sel = 0;
      m_over = 0; m_hold_hit = 0; m_hold_miss = 0;
      armed = 1;
    end else begin
      if (m_hit_ev || m_miss_ev) begin
        m_snd = SND;
        m_sel = m_miss_ev;
      end else if (m_snd > 0) begin
        m_snd--;
      end
      if (reset_score) begin
        m_hits = 0; m_misses = 0; m_mcount = 0;
        m_over = 0; m_hold_hit = 0; m_hold_miss = 0;
      end else if (m_over) begin
        m_over = 1;
      end else if (m_hold_hit) begin
        if (!wh) m_hold_hit = 0;
      end else if (m_hold_miss) begin
        if (!wm) begin
          m_hold_miss = 0;
          if (MAXM != 0 && m_mcount >= MAXM) m_over = 1;
        end
      end else if (wh) begin
        m_hits     = (m_hits + 1) % 100;
        m_hold_hit = 1;
        nh         = 1;
        exp_q.push_back({1'b0, bcd(m_hits), bcd(m_misses)});
      end else if (wm) begin
        m_misses    = (m_misses + 1) % 100;
        m_mcount    = (m_mcount < 127) ? m_mcount + 1 : 127;
        m_hold_miss = 1;
        nm          = 1;
        exp_q.push_back({1'b1, bcd(m_hits), bcd(m_misses)});
      end
    end
    m_hit_ev  = nh;
    m_miss_ev = nm;
  end

  // Monitor: sampled mid-cycle; events are matched against the scoreboard queue.
  always @(negedge clk) begin
    ev_t e;
    if (armed) begin
      check("paddle_hit", 32'(PaddleHit), 32'(in_win(int'(bx), int'(by), int'(px))));
      check("event_present", 32'(HitEvent | MissEvent), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (HitEvent || MissEvent)
          check("event_data", {14'd0, HitEvent, MissEvent, HitScore, MissScore},
                {14'd0, ~e.miss, e.miss, e.hs, e.ms});
      end
      check("hit_score", 32'(HitScore), 32'(bcd(m_hits)));
      check("miss_score", 32'(MissScore), 32'(bcd(m_misses)));
      check("game_over", 32'(GameOver), 32'(m_over));
      check("trig_sound", 32'(TrigSound), 32'(m_snd != 0));
      check("sound_sel", 32'(SoundSel), 32'(m_sel));
    end
  end

  task automatic step(input int x, input int y, input int p, input bit rs, input bit lk, input int n);
    bx          = 10'(x);
    by          = 10'(y);
    px          = 10'(p);
    reset_score = rs;
    Locked      = lk;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int p, x, y, n;
    bit lk, rs;
    // Reset held with ball in the window, then the first hit on release.
    step(300, 450, 300, 0, 0, 3);
    step(300, 450, 300, 0, 1, 2);
    step(300, 200, 300, 0, 1, 1);
    // Window edges and low-side clamp.
    step(244, 450, 300, 0, 1, 1); step(244, 200, 300, 0, 1, 1);
    step(356, 450, 300, 0, 1, 1); step(356, 200, 300, 0, 1, 1);
    step(243, 450, 300, 0, 1, 1); step(243, 200, 300, 0, 1, 1);
    step(357, 450, 300, 0, 1, 1); step(357, 200, 300, 0, 1, 1);
    step(0, 450, 20, 0, 1, 1);    step(0, 200, 20, 0, 1, 1);
    // Held in window counts once.
    step(300, 450, 300, 0, 1, 50); step(300, 200, 300, 0, 1, 1);
    // BCD carries and full wrap past 99.
    repeat (100) begin
      step(300, 450, 300, 0, 1, 1);
      step(300, 200, 300, 0, 1, 1);
    end
    // Miss limit reached, then a further miss is ignored.
    repeat (4) begin
      step(600, 470, 300, 0, 1, 2);
      step(600, 200, 300, 0, 1, 2);
    end
    step(600, 200, 300, 1, 1, 1);
    // Hit then miss two cycles later retriggers sound with the miss tone.
    step(300, 450, 300, 0, 1, 1);
    step(600, 470, 300, 0, 1, 8);
    step(600, 200, 300, 0, 1, 3);
    // Clear coincident with a hit suppresses the count.
    step(300, 450, 300, 1, 1, 1);
    step(300, 200, 300, 0, 1, 2);
    // Randomized play.
    repeat (800) begin
      lk = ($urandom_range(0, 199) != 0);
      rs = ($urandom_range(0, 39) == 0);
      p  = int'($urandom_range(0, 1023));
      x  = p + int'($urandom_range(0, 140)) - 70;
      if (x < 0) x = 0;
      if (x > 1023) x = 1023;
      case ($urandom_range(0, 4))
        0:       y = 200;
        1:       y = 450;
        2:       y = 460;
        3:       y = 470;
        default: y = int'($urandom_range(0, 1023));
      endcase
      n = int'($urandom_range(1, 4));
      step(x, y, p, rs, lk, n);
    end
    step(300, 200, 300, 0, 1, 2);
    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/score_tracker_bcd.md
Name: score_tracker_bcd

Overview:
Parametrised successor to the single-digit pong score tracker.
- Detects paddle hits and misses from ball and paddle centre coordinates.
- Keeps multi-digit BCD hit and miss counters and declares game-over after a programmable miss limit.
- Drives a stretched, retriggerable sound pulse with hit/miss tone select.
- Sits between the ball/paddle motion logic and the 7-segment score display and sound generator.

Parameters:
DIGITS, 2, number of BCD digits per score (1..4)
PADDLE_HALF, 56, paddle half-width in pixels for hit window
HIT_Y, 448, ball Y at or below which (Y >= HIT_Y) a hit can register
MISS_Y, 463, ball Y at or beyond which a non-hit counts as a miss
MAX_MISSES, 5, miss count (binary, 1..99) that triggers game-over; 0 disables game-over
SOUND_CYCLES, 2500000, TrigSound high duration in clk cycles (>=1)

Ports:
clk  in  1  system clock
Locked  in  1  synchronous active-low reset (low = reset; PLL lock)
reset_score  in  1  synchronous score/game-over clear, active high
BallCentreX  in  10  ball centre X
BallCentreY  in  10  ball centre Y
PaddleCentreX  in  10  paddle centre X
PaddleHit  out  1  combinational hit-window indicator
HitEvent  out  1  one-cycle registered pulse per counted hit
MissEvent  out  1  one-cycle registered pulse per counted miss
HitScore  out  4*DIGITS  BCD hit count, digit 0 in [3:0]
MissScore  out  4*DIGITS  BCD miss count
GameOver  out  1  high while in OVER state
TrigSound  out  1  stretched sound enable
SoundSel  out  1  0 = hit tone, 1 = miss tone

Behaviour:
- Reset (Locked=0 at clk edge):
  - state=IDLE.
  - All scores 0, HitEvent/MissEvent/GameOver/TrigSound/SoundSel 0.
  - Sound counter 0; internal binary miss count 0.
- Window arithmetic, 11-bit unsigned:
  - lo = PaddleCentreX - PADDLE_HALF, clamped to 0 on underflow.
  - hi = PaddleCentreX + PADDLE_HALF, no wrap.
  - PaddleHit = (X >= lo) && (X <= hi) && (Y >= HIT_Y).
  - PaddleMiss = (Y >= MISS_Y) && !PaddleHit.
- FSM states IDLE, HIT, MISS, OVER:
  - IDLE, PaddleHit: go HIT; increment HitScore; HitEvent=1 next cycle.
  - IDLE, PaddleMiss: go MISS; increment MissScore and binary miss count; MissEvent=1 next cycle.
  - Hit has priority: hit and miss are mutually exclusive by construction.
  - HIT: stay while PaddleHit; else go IDLE. No further counting.
  - MISS: stay while PaddleMiss; else go IDLE if miss count < MAX_MISSES, go OVER if MAX_MISSES != 0 and miss count >= MAX_MISSES.
  - OVER: no counting and no events; GameOver=1; scores frozen. Exits only via reset_score or Locked.
  - Illegal state encoding: go IDLE next cycle.
- BCD increment:
  - Ripple carry; a digit at 9 becomes 0 and carries.
  - All digits 9 wraps the whole score to 0.
  - Miss binary count saturates at 127.
- reset_score (Locked=1):
  - Next edge: scores 0, miss count 0, state IDLE, events 0.
  - Sound counter unaffected.
  - Overrides a hit/miss detected in the same cycle (no increment).
- Sound:
  - On each HitEvent/MissEvent cycle, load counter with SOUND_CYCLES and set SoundSel (0 hit, 1 miss).
  - TrigSound = (counter != 0); counter decrements each cycle to 0.
  - Retrigger while active reloads the counter and updates SoundSel.
- Latency:
  - Scores and events update 1 cycle after the detecting edge.
  - TrigSound rises the cycle after the event pulse.

Test Plan:
- Reset: Locked=0 for 3 cycles with ball in hit window -> all outputs 0; release; next edge HitScore=0x01, HitEvent single pulse.
- Window edges, PaddleCentreX=300, Y=450: X=244 and X=356 -> PaddleHit=1; X=243 and X=357 -> PaddleHit=0. PaddleCentreX=20, X=0 -> PaddleHit=1 (underflow clamp).
- BCD carry, DIGITS=2: 9 hits from 0 -> HitScore=0x09; 10th -> 0x10; from 0x99 -> 0x00. Holding ball in window 50 cycles counts once.
- Game-over, MAX_MISSES=3: three miss excursions (Y 470, then Y 200) -> MissScore=0x03, GameOver=1. A further miss -> MissScore stays 0x03, no MissEvent. reset_score -> GameOver=0, scores 0.
- Sound, SOUND_CYCLES=4: hit -> TrigSound high exactly 4 cycles, SoundSel=0. Miss 2 cycles after the hit -> counter reloaded, SoundSel=1, TrigSound high 4 cycles after reload.
- reset_score coincident with hit detection -> HitScore=0, no HitEvent, state IDLE.
